integ_dump_ctrl: RTL and testbench

INTEG_DUMP_CTRL -- requirements
Module: integ_dump_ctrl

---
 rtl/integ_dump_ctrl.sv | 148 ++++++++++++++
 tb/tb_integ_dump_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/integ_dump_ctrl.sv
// integ_dump_ctrl: integrate-and-dump controller.
//   After a start, sums cfg_len unsigned samples into an accumulator, then
//   presents the total on a valid/ready output. With cfg_cont set it re-arms
//   a new window on each accepted dump. Otherwise it returns to IDLE.
//
// Ports
//   clk, rstb            clock (rising edge), asynchronous active-low reset
//   start, abort         window request (honoured only in IDLE); abort to IDLE
//   cfg_len, cfg_cont    window length and auto-restart, latched on start
//   in_valid, in_data    sample strobe and unsigned sample
//   out_ready            consumer accepts result
//   out_valid, out_data  result handshake and integrated value
//   out_ovf              accumulator overflowed during the window
//   busy                 high in RUN or DUMP
//   drop                 sticky: a sample arrived while a result was pending
//
// Build option
//   INTEG_OVF_DET_EN  saturate the accumulator on carry-out and report it on
//                     out_ovf. When not defined, the sum wraps and out_ovf is 0.
module integ_dump_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_cont,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic             drop
);

  typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, len_q;
  logic             cont_q, ov_q, drop_q;
  logic [ACC_W-1:0] od_q;
  logic             last_smp;

`ifdef INTEG_OVF_DET_EN
  logic             wovf_q, wovf_d, oo_q;
  logic [ACC_W:0]   sum_full;

  // A carry out pins the accumulator at all-ones. Later adds keep it there
  // because a saturated value plus any nonzero sample carries again.
  assign sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - N){1'b0}}, in_data};
  assign acc_d    = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  assign wovf_d   = wovf_q | sum_full[ACC_W];
  assign out_ovf  = oo_q;
`else
  assign acc_d    = acc_q + ACC_W'(in_data);
  assign out_ovf  = 1'b0;
`endif

  // cnt_q < len_q always holds in RUN, so cnt_q+1 cannot wrap.
  assign last_smp  = (cnt_q + CNT_W'(1)) == len_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign drop      = drop_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      cont_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      drop_q  <= 1'b0;
`ifdef INTEG_OVF_DET_EN
      wovf_q  <= 1'b0;
      oo_q    <= 1'b0;
`endif
    end else if (abort) begin
      // Abort outranks start, samples and the output handshake.
      state_q <= IDLE;
      ov_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef INTEG_OVF_DET_EN
      wovf_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (cfg_len != '0)) begin
            len_q   <= cfg_len;
            cont_q  <= cfg_cont;
            acc_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
`ifdef INTEG_OVF_DET_EN
            wovf_q  <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef INTEG_OVF_DET_EN
            wovf_q <= wovf_d;
`endif
            if (last_smp) begin
              od_q    <= acc_d;
              ov_q    <= 1'b1;
`ifdef INTEG_OVF_DET_EN
              oo_q    <= wovf_d;
`endif
              state_q <= DUMP;
            end
          end
        end
        DUMP: begin
          if (in_valid) drop_q <= 1'b1;
          if (out_ready) begin
            ov_q <= 1'b0;
            if (cont_q) begin
              acc_q   <= '0;
              cnt_q   <= '0;
`ifdef INTEG_OVF_DET_EN
              wovf_q  <= 1'b0;
`endif
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integ_dump_ctrl.sv
module tb_integ_dump_ctrl;
  localparam int N = 4, CNT_W = 8, ACC_W = 4;
  localparam int MAXV = (1 << ACC_W) - 1;

  logic clk = 1'b0, rstb = 1'b0;
  logic start = 0, abort = 0, cfg_cont = 0, in_valid = 0, out_ready = 0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [N-1:0] in_data = '0;
  logic out_valid, out_ovf, busy, drop;
  logic [ACC_W-1:0] out_data;

  integ_dump_ctrl #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .cfg_len(cfg_len),
    .cfg_cont(cfg_cont), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy), .drop(drop));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the phase and the list of samples taken in the
  // current window. The result is computed from the full-precision sum.
  int m_mode = 0;          // 0 idle, 1 collecting, 2 result pending
  int m_win[$];
  int m_len = 0;
  bit m_cont = 0, m_ov = 0, m_oo = 0, m_drop = 0;
  int m_od = 0;

  task automatic model_rst();
    m_mode = 0; m_win.delete(); m_len = 0; m_cont = 0;
    m_ov = 0; m_oo = 0; m_drop = 0; m_od = 0;
  endtask

  task automatic model_step(input bit st, input bit ab, input int ln, input bit ct,
                            input bit iv, input int d, input bit rdy);
    int s;
    if (ab) begin
      m_mode = 0; m_ov = 0; m_win.delete();
    end else if (m_mode == 0) begin
      if (st && ln != 0) begin
        m_len = ln; m_cont = ct; m_win.delete(); m_drop = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (iv) begin
        m_win.push_back(d);
        if (m_win.size() == m_len) begin
          s = 0;
          foreach (m_win[i]) s += m_win[i];
`ifdef INTEG_OVF_DET_EN
          m_oo = (s > MAXV);
          m_od = m_oo ? MAXV : s;
`else
          m_oo = 0;
          m_od = s % (MAXV + 1);
`endif
          m_ov = 1; m_mode = 2;
        end
      end
    end else begin
      if (iv) m_drop = 1;
      if (rdy) begin
        m_ov = 0; m_win.delete();
        m_mode = m_cont ? 1 : 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},  32'(busy),      32'(m_mode != 0));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".drop"},  32'(drop),      32'(m_drop));
    chk({tag, ".data"},  32'(out_data),  32'(m_od));
    chk({tag, ".ovf"},   32'(out_ovf),   32'(m_oo));
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic cyc(input string tag, input bit st, input bit ab, input int ln, input bit ct,
                     input bit iv, input int d, input bit rdy);
    start = st; abort = ab; cfg_len = CNT_W'(ln); cfg_cont = ct;
    in_valid = iv; in_data = N'(d); out_ready = rdy;
    model_step(st, ab, ln, ct, iv, d, rdy);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // Reset asserted between edges; the outputs must clear without a clock.
  task automatic do_reset(input string tag);
    start = 0; abort = 0; in_valid = 0; out_ready = 0;
    #2 rstb = 1'b0;
    #1;
    model_rst();
    check_all({tag, ".async"});
    @(posedge clk); #1;
    rstb = 1'b1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    model_rst();
    @(posedge clk); #1;
    check_all("rst0");
    rstb = 1'b1;

    // Contiguous window of four, single shot.
    cyc("r33", 1, 0, 4, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("r33", 0, 0, 0, 0, 1, i, 0);
    chk("r33_sum", 32'(out_data), 10);
    cyc("r33", 0, 0, 0, 0, 0, 0, 1);
    chk("r33_idle", 32'(busy), 0);

    // Gapped samples, then the result held back while samples keep arriving.
    cyc("r34", 1, 0, 3, 0, 0, 0, 0);
    cyc("r34", 0, 0, 0, 0, 1, 2, 0);
    cyc("r34", 0, 0, 0, 0, 0, 9, 0);
    cyc("r34", 0, 0, 0, 0, 1, 3, 0);
    cyc("r34", 0, 0, 0, 0, 0, 0, 0);
    cyc("r34", 0, 0, 0, 0, 1, 4, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("r34", 0, 0, 0, 0, 1, i, 0);
      chk("r34_hold", 32'(out_data), 9);
    end
    chk("r34_drop", 32'(drop), 1);
    cyc("r34", 0, 0, 0, 0, 0, 0, 1);

    // Continuous mode, two windows back to back.
    cyc("r35", 1, 0, 2, 1, 0, 0, 1);
    cyc("r35", 0, 0, 0, 0, 1, 5, 1);
    cyc("r35", 0, 0, 0, 0, 1, 5, 1);
    chk("r35_w0", 32'(out_data), 10);
    cyc("r35", 0, 0, 0, 0, 0, 0, 1);
    cyc("r35", 0, 0, 0, 0, 1, 7, 1);
    cyc("r35", 0, 0, 0, 0, 1, 7, 1);
    chk("r35_w1", 32'(out_data), 14);
    cyc("r35", 0, 1, 0, 0, 0, 0, 1);

    // Overflow of a 4-bit accumulator.
    cyc("r36", 1, 0, 2, 0, 0, 0, 0);
    cyc("r36", 0, 0, 0, 0, 1, 15, 0);
    cyc("r36", 0, 0, 0, 0, 1, 15, 0);
`ifdef INTEG_OVF_DET_EN
    chk("r36_data", 32'(out_data), 15);
    chk("r36_ovf",  32'(out_ovf), 1);
`else
    chk("r36_data", 32'(out_data), 14);
    chk("r36_ovf",  32'(out_ovf), 0);
`endif
    cyc("r36", 0, 0, 0, 0, 0, 0, 1);

    // Abort and reset while collecting and while a result is pending.
    cyc("r37a", 1, 0, 3, 0, 0, 0, 0);
    cyc("r37a", 0, 0, 0, 0, 1, 1, 0);
    cyc("r37a", 0, 1, 0, 0, 1, 1, 0);
    cyc("r37b", 1, 0, 1, 0, 0, 0, 0);
    cyc("r37b", 0, 0, 0, 0, 1, 3, 0);
    cyc("r37b", 1, 1, 2, 0, 1, 2, 1);
    chk("r37b_nv", 32'(out_valid), 0);
    cyc("r37c", 1, 0, 2, 0, 0, 0, 0);
    cyc("r37c", 0, 0, 0, 0, 1, 6, 0);
    do_reset("r37c");
    cyc("r37d", 1, 0, 1, 0, 0, 0, 0);
    cyc("r37d", 0, 0, 0, 0, 1, 6, 0);
    do_reset("r37d");
    cyc("r37e", 1, 0, 0, 1, 1, 1, 1);
    chk("r37e_idle", 32'(busy), 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset("rnd");
      cyc("rnd",
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
          int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 60, int'($urandom_range(0, 15)),
          $urandom_range(0, 99) < 50);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
